// File: rtl/instruction_buffer.sv
// instruction_buffer: decoupling FIFO between fetch/decode and dispatch (feeds the ROB).
//
// Also holds instruction_buffer_pkg, which defines the DP_PACKET and SQUASH_PACKET types.
//
// Ports:
//   clock                          : system clock, rising edge
//   reset                          : asynchronous, active-low reset
//   if_ib_packet / if_ib_valid     : decoded packet from decode and its valid
//   ib_if_ready                    : buffer can accept an enqueue this cycle
//   instructions_buffer_rob_packet : oldest entry, presented to the ROB ('0 when empty)
//   dp_rob_available               : instructions_buffer_rob_packet is valid
//   rob_dp_available               : ROB accepts the presented packet this cycle
//   squash_packet                  : only squash_valid is used; flushes the whole buffer
//   ib_count                       : current occupancy
//
// Optional feature (macro IB_BYPASS_EN): when the buffer is empty, an incoming packet is
// presented to the ROB in the same cycle. If the ROB takes it, the packet is never written.

package instruction_buffer_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_store;
        logic        valid;
    } DP_PACKET;

    typedef struct packed {
        logic        squash_valid;
        logic [31:0] squash_pc;
    } SQUASH_PACKET;

endpackage

module instruction_buffer
    import instruction_buffer_pkg::*;
#(
    parameter int unsigned IB_SZ    = 8,
    parameter int unsigned IB_CNT_W = $clog2(IB_SZ + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  DP_PACKET            if_ib_packet,
    input  logic                if_ib_valid,
    output logic                ib_if_ready,
    output DP_PACKET            instructions_buffer_rob_packet,
    output logic                dp_rob_available,
    input  logic                rob_dp_available,
    input  SQUASH_PACKET        squash_packet,
    output logic [IB_CNT_W-1:0] ib_count
);

    localparam int unsigned PtrW = $clog2(IB_SZ);

    DP_PACKET              entries_q [IB_SZ];
    DP_PACKET              entries_d [IB_SZ];
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [IB_CNT_W-1:0]   count_q, count_d;

    logic squash;
    logic not_empty;
    logic enq_fire;   // handshake with decode completes
    logic enq_write;  // packet actually lands in storage
    logic deq_mem;    // stored head entry leaves
    logic bypass;     // incoming packet presented directly (empty buffer)

    // Only squash_valid matters; the rest of the squash packet is deliberately ignored.
    logic unused_squash_pc;
    assign unused_squash_pc = ^squash_packet.squash_pc;

    assign squash    = squash_packet.squash_valid;
    assign not_empty = (count_q != '0);

    // Readiness looks only at registered occupancy, so a full buffer never takes a packet
    // even in a cycle where the ROB drains one.
    assign ib_if_ready = (count_q < IB_CNT_W'(IB_SZ));
    assign enq_fire    = if_ib_valid && ib_if_ready;

`ifdef IB_BYPASS_EN
    assign bypass = !not_empty && if_ib_valid && !squash;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed packet the ROB accepts is consumed in flight and never stored.
    assign enq_write = enq_fire && !(bypass && rob_dp_available);
    assign deq_mem   = not_empty && rob_dp_available;

    always_comb begin
        dp_rob_available               = not_empty || bypass;
        instructions_buffer_rob_packet = '0;
        if (not_empty) begin
            instructions_buffer_rob_packet = entries_q[head_q];
        end else if (bypass) begin
            instructions_buffer_rob_packet = if_ib_packet;
        end
    end

    assign ib_count = count_q;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (squash) begin
            // Flush wins over any enqueue/dequeue in the same cycle.
            for (int i = 0; i < IB_SZ; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_write) begin
                entries_d[tail_q] = if_ib_packet;
                tail_d = (tail_q == PtrW'(IB_SZ - 1)) ? '0 : tail_q + PtrW'(1);
            end
            // head != tail whenever deq_mem and enq_write coincide (buffer neither empty
            // nor full), so the clear below never hits the slot just written.
            if (deq_mem) begin
                entries_d[head_q] = '0;
                head_d = (head_q == PtrW'(IB_SZ - 1)) ? '0 : head_q + PtrW'(1);
            end
            unique case ({enq_write, deq_mem})
                2'b10:   count_d = count_q + IB_CNT_W'(1);
                2'b01:   count_d = count_q - IB_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IB_SZ; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_instruction_buffer.sv
// Self-checking bench for instruction_buffer: directed vector table, hand-written corner
// sequences (in-order streaming with wrap, mid-stream reset, bypass) and a random phase
// checked against a queue-based reference model.

module tb_instruction_buffer;
    import instruction_buffer_pkg::*;

    localparam int unsigned IB_SZ    = 8;
    localparam int unsigned IB_CNT_W = $clog2(IB_SZ + 1);

    logic                clock;
    logic                reset;
    DP_PACKET            if_ib_packet;
    logic                if_ib_valid;
    logic                ib_if_ready;
    DP_PACKET            instructions_buffer_rob_packet;
    logic                dp_rob_available;
    logic                rob_dp_available;
    SQUASH_PACKET        squash_packet;
    logic [IB_CNT_W-1:0] ib_count;

    instruction_buffer #(
        .IB_SZ    (IB_SZ),
        .IB_CNT_W (IB_CNT_W)
    ) dut (
        .clock                          (clock),
        .reset                          (reset),
        .if_ib_packet                   (if_ib_packet),
        .if_ib_valid                    (if_ib_valid),
        .ib_if_ready                    (ib_if_ready),
        .instructions_buffer_rob_packet (instructions_buffer_rob_packet),
        .dp_rob_available               (dp_rob_available),
        .rob_dp_available               (rob_dp_available),
        .squash_packet                  (squash_packet),
        .ib_count                       (ib_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the buffer contents, oldest first.
    DP_PACKET model_q[$];
    DP_PACKET last_acc;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic DP_PACKET mk_pkt(input logic [31:0] pc);
        DP_PACKET p;
        p.pc       = pc;
        p.inst     = ~pc ^ 32'h1357_9bdf;
        p.is_store = pc[2];
        p.valid    = 1'b1;
        return p;
    endfunction

    // Drive one cycle of inputs, check same-cycle outputs against the model, clock it,
    // then advance the model. Starts and ends 1 time unit after a rising edge.
    task automatic cycle(input logic v, input DP_PACKET p, input logic rob, input logic sq);
        DP_PACKET exp_pkt;
        logic     exp_av;
        logic     exp_rdy;
        logic     byp;
        if_ib_valid                = v;
        if_ib_packet               = p;
        rob_dp_available           = rob;
        squash_packet.squash_valid = sq;
        squash_packet.squash_pc    = $urandom;
        #1;
        exp_rdy = (model_q.size() < IB_SZ);
        exp_av  = (model_q.size() != 0);
        exp_pkt = exp_av ? model_q[0] : '0;
        byp     = 1'b0;
`ifdef IB_BYPASS_EN
        if (!exp_av && v && !sq) begin
            byp     = 1'b1;
            exp_av  = 1'b1;
            exp_pkt = p;
        end
`endif
        chk("ready", 80'(ib_if_ready), 80'(exp_rdy));
        chk("avail", 80'(dp_rob_available), 80'(exp_av));
        chk("packet", 80'(instructions_buffer_rob_packet), 80'(exp_pkt));
        chk("count", 80'(ib_count), 80'(model_q.size()));
        if (dp_rob_available && rob) last_acc = instructions_buffer_rob_packet;
        @(posedge clock);
        if (sq) begin
            model_q.delete();
        end else begin
            if (exp_av && rob && !byp) void'(model_q.pop_front());
            if (v && exp_rdy && !(byp && rob)) model_q.push_back(p);
        end
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        rob;
        logic        sq;
        int          exp_cnt;
        logic        exp_av;
        logic        exp_rdy;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Expected values are the state after the clock edge of each vector.
        vecs.push_back('{1'b1, 32'h00, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{1'b1, 32'h04, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{1'b1, 32'h08, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{1'b1, 32'h0c, 1'b0, 1'b0, 4, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{1'b1, 32'h10, 1'b0, 1'b0, 5, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{1'b1, 32'h14, 1'b0, 1'b0, 6, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{1'b1, 32'h18, 1'b0, 1'b0, 7, 1'b1, 1'b1, 32'h00});
        vecs.push_back('{1'b1, 32'h1c, 1'b0, 1'b0, 8, 1'b1, 1'b0, 32'h00});
        vecs.push_back('{1'b1, 32'h20, 1'b0, 1'b0, 8, 1'b1, 1'b0, 32'h00}); // dropped: full
        vecs.push_back('{1'b1, 32'h24, 1'b1, 1'b0, 7, 1'b1, 1'b1, 32'h04}); // dequeue only
        vecs.push_back('{1'b1, 32'h28, 1'b1, 1'b0, 7, 1'b1, 1'b1, 32'h08}); // tail wraps
        vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 6, 1'b1, 1'b1, 32'h0c});
        vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 5, 1'b1, 1'b1, 32'h10});
        vecs.push_back('{1'b1, 32'h2c, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h00}); // squash drops 2c
        vecs.push_back('{1'b1, 32'h30, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h30});
        vecs.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 32'h00});

        reset                   = 1'b0;
        if_ib_valid             = 1'b0;
        if_ib_packet            = '0;
        rob_dp_available        = 1'b0;
        squash_packet           = '0;
        #2;
        chk("rst_count", 80'(ib_count), 80'(0));
        chk("rst_avail", 80'(dp_rob_available), 80'(0));
        chk("rst_ready", 80'(ib_if_ready), 80'(1));
        chk("rst_packet", 80'(instructions_buffer_rob_packet), 80'(0));
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Directed vector table.
        foreach (vecs[i]) begin
            cycle(vecs[i].v, mk_pkt(vecs[i].pc), vecs[i].rob, vecs[i].sq);
            chk($sformatf("vec%0d_count", i), 80'(ib_count), 80'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_avail", i), 80'(dp_rob_available), 80'(vecs[i].exp_av));
            chk($sformatf("vec%0d_ready", i), 80'(ib_if_ready), 80'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_pc", i), 80'(instructions_buffer_rob_packet.pc),
                80'(vecs[i].exp_pc));
        end

        // Continuous enqueue+dequeue streaming: order preserved, pointers wrap, count fixed.
        for (int k = 0; k < 3; k++) cycle(1'b1, mk_pkt(32'h100 + 32'(4 * k)), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, mk_pkt(32'h10c + 32'(4 * k)), 1'b1, 1'b0);
            chk($sformatf("pair%0d_pc", k), 80'(last_acc.pc), 80'(32'h100 + 32'(4 * k)));
            chk($sformatf("pair%0d_count", k), 80'(ib_count), 80'(3));
        end

        // Mid-stream reset clears outputs before the next clock edge.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cycle(1'b1, mk_pkt(32'h200 + 32'(4 * k)), 1'b0, 1'b0);
        chk("pre_rst_count", 80'(ib_count), 80'(4));
        if_ib_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_count", 80'(ib_count), 80'(0));
        chk("async_rst_avail", 80'(dp_rob_available), 80'(0));
        chk("async_rst_ready", 80'(ib_if_ready), 80'(1));
        chk("async_rst_packet", 80'(instructions_buffer_rob_packet), 80'(0));
        model_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;

`ifdef IB_BYPASS_EN
        // Bypass: empty buffer, ROB takes the packet in the same cycle.
        if_ib_valid                = 1'b1;
        if_ib_packet               = mk_pkt(32'h40);
        rob_dp_available           = 1'b1;
        squash_packet.squash_valid = 1'b0;
        #1;
        chk("bypass_avail", 80'(dp_rob_available), 80'(1));
        chk("bypass_pc", 80'(instructions_buffer_rob_packet.pc), 80'(32'h40));
        @(posedge clock);
        #1;
        if_ib_valid = 1'b0;
        #1;
        chk("bypass_count", 80'(ib_count), 80'(0));
        chk("bypass_after_avail", 80'(dp_rob_available), 80'(0));
`endif

        // Random traffic against the reference model.
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(0, 9) < 7), mk_pkt($urandom), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_buffer.md
Name: instruction_buffer

Overview:
- Decoupling FIFO between fetch/decode and dispatch; the upstream neighbour of the ROB.
- Accepts decoded DP_PACKETs from decode and presents the oldest one to the ROB.
- Dequeues on the ROB handshake (dp_rob_available out, rob_dp_available in).
- Flushes completely on a branch-mispredict squash.

Parameters:
IB_SZ, 8, queue depth in entries; any value >= 2, not restricted to a power of two.
IB_CNT_W, $clog2(IB_SZ+1), width of the occupancy counter.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
if_ib_packet  input  $bits(DP_PACKET)  decoded instruction from decode.
if_ib_valid  input  1  if_ib_packet is valid this cycle.
ib_if_ready  output  1  buffer can accept an enqueue this cycle.
instructions_buffer_rob_packet  output  $bits(DP_PACKET)  oldest entry, presented to the ROB.
dp_rob_available  output  1  instructions_buffer_rob_packet is valid.
rob_dp_available  input  1  ROB accepts a packet this cycle.
squash_packet  input  $bits(SQUASH_PACKET)  only squash_valid is used.
ib_count  output  IB_CNT_W  current occupancy.

Behaviour:
- Storage: entry array [IB_SZ-1:0], head and tail pointers, and a count register.
  - Pointers wrap from IB_SZ-1 to 0 by explicit compare, not by modulo of a power of two.
- Reset (reset==0, asynchronous):
  - head=0, tail=0, count=0, all entries cleared to '0.
  - Outputs: dp_rob_available=0, ib_if_ready=1, ib_count=0, instructions_buffer_rob_packet='0.
- Enqueue: fires when if_ib_valid && ib_if_ready.
  - Writes entry[tail]; tail advances by 1 with wrap.
  - The packet is stored verbatim; its internal valid field is not inspected.
- ib_if_ready = (count < IB_SZ). Combinational from registered count only.
  - No same-cycle enqueue into a full buffer, even if a dequeue occurs in that cycle.
- Dequeue: fires when dp_rob_available && rob_dp_available.
  - head advances with wrap; the vacated entry is cleared to '0.
- Output drive:
  - dp_rob_available = (count != 0).
  - instructions_buffer_rob_packet = entry[head] when count != 0, else '0.
- The ROB deasserts rob_dp_available both when it is full and when the head packet is a STORE while the ROB is non-empty.
  - The buffer holds head and output stable until acceptance; no reordering, no skipping.
- Count update:
  - +1 on enqueue only, -1 on dequeue only.
  - Unchanged on simultaneous enqueue+dequeue, with both pointers advancing.
- Latency: a packet enqueued at edge N is visible to the ROB at output after edge N, i.e. 1 cycle minimum (see optional feature).
- Squash: when squash_packet.squash_valid=1 at a rising edge, the flush has priority over enqueue and dequeue in that cycle.
  - head=tail=0, count=0, entries cleared.
  - A packet presented with if_ib_valid in the squash cycle is dropped.
  - The cycle after squash, ib_if_ready=1 and dp_rob_available=0.
- Reset assertion mid-operation clears state immediately, independent of clock.
  - Deassertion is expected synchronous to clock and is handled by the top level.
- ib_count always equals the number of valid entries and never exceeds IB_SZ.

Optional Feature:
- Macro: IB_BYPASS_EN.
- Defined:
  - When count==0 and if_ib_valid=1, the incoming packet drives instructions_buffer_rob_packet and dp_rob_available=1 combinationally in the same cycle.
  - If rob_dp_available=1 in that cycle, the packet is consumed and not written, and count stays 0.
  - Otherwise it is written normally.
  - A squash in the same cycle forces dp_rob_available=0.
- Undefined: no bypass; minimum latency is 1 cycle as above.

Test Plan:
- Reset, then enqueue 3 packets (pc 0x0, 0x4, 0x8) with rob_dp_available=0 -> ib_count=3, dp_rob_available=1, head packet pc=0x0.
- Fill to IB_SZ=8 with rob_dp_available=0 -> ib_if_ready=0 after the 8th enqueue; a 9th presented packet is not stored and count stays 8.
- Full buffer, then drive rob_dp_available=1 and if_ib_valid=1 together -> dequeue only, count goes 8->7; next cycle ib_if_ready=1.
- Run 20 enqueue+dequeue pairs continuously -> ROB receives pcs in order, head/tail wrap past 7->0, count stays constant, no loss or duplication.
- Count=5 with squash_valid=1 and if_ib_valid=1 in the same cycle -> next cycle count=0, dp_rob_available=0, the incoming packet is absent.
- Hold reset low mid-stream with count=4 -> outputs clear asynchronously before the next clock edge.
- With IB_BYPASS_EN: from an empty buffer, present pc=0x40 with rob_dp_available=1 -> ROB sees pc=0x40 in the same cycle and count stays 0.
